// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU load/store
// path (port 0) and the loader/debug port (port 1). Request/grant/ack
// handshake, round-robin tie-break, fixed-latency memory sequencing.
// Optional build macro CPU_PRIORITY_EN: port 0 always wins a simultaneous
// request (fixed priority) and the round-robin history is dropped.
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic [1:0]        Grant,
  output logic [1:0]        Ack,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              MemEN,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // MEM_LAT is limited to 1..15, so four bits hold the countdown.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_t              state;
  state_t              state_nxt;
  logic                any_req;
  logic                winner;
  logic                winner_nxt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic [3:0]          cnt;
`ifndef CPU_PRIORITY_EN
  logic                last_grant;
`endif

  assign any_req = Req0 | Req1;

  // Pick the port that would win if the arbiter were sampling now.
  always_comb begin
    winner_nxt = 1'b0;
    if (Req0 && Req1) begin
`ifdef CPU_PRIORITY_EN
      winner_nxt = 1'b0;
`else
      winner_nxt = ~last_grant;
`endif
    end else if (Req1) begin
      winner_nxt = 1'b1;
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing: one ACCESS cycle, MEM_LAT WAIT cycles, one DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner and its request; inputs are ignored outside IDLE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      winner    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      winner    <= winner_nxt;
      lat_we    <= winner_nxt ? We1    : We0;
      lat_addr  <= winner_nxt ? Addr1  : Addr0;
      lat_wdata <= winner_nxt ? WData1 : WData0;
    end
  end

  // Latency counter: loaded in ACCESS, counts down through WAIT.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                cnt <= 4'd0;
    else if (state == ACCESS)  cnt <= LAT_LOAD;
    else if (state == WAIT)    cnt <= cnt - 4'd1;
  end

  // Capture read data in the last WAIT cycle; writes leave RData alone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                       rdata_q <= '0;
    else if (state == WAIT && cnt == 4'd1 && !lat_we) rdata_q <= MemRData;
  end

`ifndef CPU_PRIORITY_EN
  // Round-robin history; reset value lets port 0 win the first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              last_grant <= 1'b1;
    else if (state == DONE)  last_grant <= winner;
  end
`endif

  assign Grant    = (state == IDLE) ? 2'b00 : (winner ? 2'b10 : 2'b01);
  assign Ack      = (state == DONE) ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign Busy     = (state != IDLE);
  assign MemEN    = (state == ACCESS);
  assign MemWE    = (state == ACCESS) && lat_we;
  assign MemAddr  = lat_addr;
  assign MemWData = lat_wdata;
  assign RData    = rdata_q;

endmodule
